// File: rtl/wt_dcache_inval_queue.sv
// Queued bus-invalidation unit for the write-through L1 D$: buffers requests, does a
// tag-only lookup per entry and issues one miss-unit invalidation per hit way (or one flush).
module wt_dcache_inval_queue #(
  parameter int unsigned PlenWidth  = 56,
  parameter int unsigned OffWidth   = 4,
  parameter int unsigned ClIdxWidth = 8,
  parameter int unsigned NumWays    = 8,
  parameter int unsigned FifoDepth  = 4,
  parameter bit          CoalesceEn = 1'b1,
  localparam int unsigned TagW      = PlenWidth - OffWidth - ClIdxWidth,
  localparam int unsigned WayW      = (NumWays > 1) ? $clog2(NumWays) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  mem_inv_req_i,
  input  logic [PlenWidth-1:0]  mem_inv_paddr_i,
  input  logic                  mem_inv_all_i,
  output logic                  mem_inv_ack_o,
  output logic                  rd_req_o,
  output logic [TagW-1:0]       rd_tag_o,
  output logic [ClIdxWidth-1:0] rd_idx_o,
  output logic [OffWidth-1:0]   rd_off_o,
  output logic                  rd_tag_only_o,
  input  logic                  rd_ack_i,
  input  logic [NumWays-1:0]    rd_vld_bits_i,
  input  logic [NumWays-1:0]    rd_hit_oh_i,
  output logic                  inv_vld_o,
  output logic                  inv_all_o,
  output logic [ClIdxWidth-1:0] inv_idx_o,
  output logic [WayW-1:0]       inv_way_o,
  input  logic                  inv_ack_i,
  output logic                  busy_o
);

  localparam int unsigned LineW = PlenWidth - OffWidth;
  localparam int unsigned PtrW  = $clog2(FifoDepth);

  typedef enum logic [2:0] {IDLE, LOOKUP, RESULT, WAY_REQ, ALL_REQ} state_e;

  state_e               state_q, state_d;
  logic [LineW-1:0]     line_q [FifoDepth];
  logic [LineW-1:0]     line_d [FifoDepth];
  logic [FifoDepth-1:0] all_q, all_d;
  logic [PtrW:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NumWays-1:0]   mask_q, mask_d;

  logic [PtrW:0]        count;
  logic                 full, empty, push, pop, coal_hit, head_busy;
  logic [PtrW-1:0]      slot_ofs;
  logic [LineW-1:0]     in_line, head_line;
  logic                 head_all;
  logic [WayW-1:0]      low_way;
  logic [NumWays-1:0]   low_oh;
  logic                 unused_off;

  assign unused_off = ^mem_inv_paddr_i[OffWidth-1:0];

  assign count     = wr_ptr_q - rd_ptr_q;
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                     (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign in_line   = mem_inv_paddr_i[PlenWidth-1:OffWidth];
  assign head_line = line_q[rd_ptr_q[PtrW-1:0]];
  assign head_all  = all_q[rd_ptr_q[PtrW-1:0]];
  assign head_busy = (state_q != IDLE);

  assign mem_inv_ack_o = mem_inv_req_i & ~full;
  assign push          = mem_inv_ack_o & ~((CoalesceEn != 1'b0) & ~mem_inv_all_i & coal_hit);
  assign rd_off_o      = '0;
  assign rd_tag_only_o = 1'b1;
  assign busy_o        = ~empty | head_busy;

  // Once the head is being looked up its result may predate the new request, so it never absorbs one.
  always_comb begin
    coal_hit = 1'b0;
    slot_ofs = '0;
    for (int i = 0; i < FifoDepth; i++) begin
      slot_ofs = PtrW'(i) - rd_ptr_q[PtrW-1:0];
      if (({1'b0, slot_ofs} < count) && !all_q[i] && (line_q[i] == in_line) &&
          !(head_busy && (slot_ofs == '0))) begin
        coal_hit = 1'b1;
      end
    end
  end

  always_comb begin
    low_way = '0;
    low_oh  = '0;
    for (int w = NumWays - 1; w >= 0; w--) begin
      if (mask_q[w]) begin
        low_way   = WayW'(w);
        low_oh    = '0;
        low_oh[w] = 1'b1;
      end
    end
  end

  always_comb begin
    line_d = line_q;
    all_d  = all_q;
    if (push) begin
      line_d[wr_ptr_q[PtrW-1:0]] = in_line;
      all_d[wr_ptr_q[PtrW-1:0]]  = mem_inv_all_i;
    end
    wr_ptr_d = wr_ptr_q + {{PtrW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{PtrW{1'b0}}, pop};
  end

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    pop       = 1'b0;
    rd_req_o  = 1'b0;
    rd_tag_o  = '0;
    rd_idx_o  = '0;
    inv_vld_o = 1'b0;
    inv_all_o = 1'b0;
    inv_idx_o = '0;
    inv_way_o = '0;
    case (state_q)
      IDLE: begin
        if (!empty) state_d = head_all ? ALL_REQ : LOOKUP;
      end
      LOOKUP: begin
        rd_req_o = 1'b1;
        rd_tag_o = head_line[LineW-1:ClIdxWidth];
        rd_idx_o = head_line[ClIdxWidth-1:0];
        if (rd_ack_i) state_d = RESULT;
      end
      RESULT: begin
        mask_d = rd_vld_bits_i & rd_hit_oh_i;
        if (mask_d == '0) begin
          pop     = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = WAY_REQ;
        end
      end
      WAY_REQ: begin
        inv_vld_o = 1'b1;
        inv_idx_o = head_line[ClIdxWidth-1:0];
        inv_way_o = low_way;
        if (inv_ack_i) begin
          mask_d = mask_q & ~low_oh;
          if (mask_d == '0) begin
            pop     = 1'b1;
            state_d = IDLE;
          end
        end
      end
      ALL_REQ: begin
        inv_vld_o = 1'b1;
        inv_all_o = 1'b1;
        if (inv_ack_i) begin
          pop     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      all_q    <= '0;
      for (int i = 0; i < FifoDepth; i++) line_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      all_q    <= all_d;
      line_q   <= line_d;
    end
  end

endmodule

// File: tb/tb_wt_dcache_inval_queue.sv
// Directed bench: stimulus pushes expected lookups/invalidations into queues, separate
// responder/monitor processes answer the DUT and compare at each handshake.
module tb_wt_dcache_inval_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, all_i, rd_ack, inv_ack;
  logic [55:0] paddr;
  logic [7:0]  vld, hit;

  logic        ack, rd_req, rd_to, inv_vld, inv_all, busy;
  logic [43:0] rd_tag;
  logic [7:0]  rd_idx, inv_idx;
  logic [3:0]  rd_off;
  logic [2:0]  inv_way;

  logic        nc_ack, nc_rd_req, nc_rd_to, nc_inv_vld, nc_inv_all, nc_busy;
  logic [43:0] nc_rd_tag;
  logic [7:0]  nc_rd_idx, nc_inv_idx;
  logic [3:0]  nc_rd_off;
  logic [2:0]  nc_inv_way;

  logic [51:0] exp_rd_q[$];
  logic [15:0] resp_q[$];
  logic [11:0] exp_inv_q[$];

  int checks = 0;
  int errors = 0;
  int rd_ack_en = 1;
  int inv_delay = 0;

  wt_dcache_inval_queue dut (
    .clk_i(clk), .rst_ni(rst_n),
    .mem_inv_req_i(req), .mem_inv_paddr_i(paddr), .mem_inv_all_i(all_i), .mem_inv_ack_o(ack),
    .rd_req_o(rd_req), .rd_tag_o(rd_tag), .rd_idx_o(rd_idx), .rd_off_o(rd_off),
    .rd_tag_only_o(rd_to), .rd_ack_i(rd_ack), .rd_vld_bits_i(vld), .rd_hit_oh_i(hit),
    .inv_vld_o(inv_vld), .inv_all_o(inv_all), .inv_idx_o(inv_idx), .inv_way_o(inv_way),
    .inv_ack_i(inv_ack), .busy_o(busy)
  );

  wt_dcache_inval_queue #(.CoalesceEn(1'b0)) dut_nc (
    .clk_i(clk), .rst_ni(rst_n),
    .mem_inv_req_i(req), .mem_inv_paddr_i(paddr), .mem_inv_all_i(all_i), .mem_inv_ack_o(nc_ack),
    .rd_req_o(nc_rd_req), .rd_tag_o(nc_rd_tag), .rd_idx_o(nc_rd_idx), .rd_off_o(nc_rd_off),
    .rd_tag_only_o(nc_rd_to), .rd_ack_i(rd_ack), .rd_vld_bits_i(vld), .rd_hit_oh_i(hit),
    .inv_vld_o(nc_inv_vld), .inv_all_o(nc_inv_all), .inv_idx_o(nc_inv_idx), .inv_way_o(nc_inv_way),
    .inv_ack_i(inv_ack), .busy_o(nc_busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // driver tasks
  task automatic expect_line(input logic [55:0] pa, input logic [7:0] v, input logic [7:0] h);
    exp_rd_q.push_back({pa[55:12], pa[11:4]});
    resp_q.push_back({v, h});
  endtask

  task automatic exp_inv(input logic a, input logic [7:0] idx, input logic [2:0] way);
    exp_inv_q.push_back({a, idx, way});
  endtask

  task automatic send(input logic [55:0] pa, input logic a, input logic exp_ack,
                      input logic chk_nc, input logic exp_nc, input string nm);
    req = 1'b1; paddr = pa; all_i = a;
    #1;
    chk(nm, ack, exp_ack);
    if (chk_nc) chk({nm, "_nc"}, nc_ack, exp_nc);
    @(negedge clk);
    req = 1'b0; paddr = '0; all_i = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_busy_done"}, busy, 0);
    chk({nm, "_inv_q_empty"}, exp_inv_q.size(), 0);
    chk({nm, "_rd_q_empty"}, exp_rd_q.size(), 0);
  endtask

  // lookup responder: acks rd_req, returns vld/hit the cycle after the handshake
  initial begin
    logic        pending;
    logic [15:0] nxt;
    logic [51:0] e;
    pending = 1'b0; nxt = '0;
    rd_ack = 1'b0; vld = '0; hit = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pending = 1'b0; rd_ack = 1'b0; vld = '0; hit = '0;
      end else begin
        if (pending) begin
          vld = nxt[15:8]; hit = nxt[7:0];
        end else begin
          vld = '0; hit = '0;
        end
        rd_ack  = (rd_ack_en != 0) && rd_req;
        pending = rd_ack && rd_req;
        if (pending) begin
          chk("rd_expected", exp_rd_q.size() != 0, 1);
          chk("resp_expected", resp_q.size() != 0, 1);
          chk("rd_off", rd_off, 0);
          if (exp_rd_q.size() != 0) begin
            e = exp_rd_q.pop_front();
            chk("rd_tag", rd_tag, e[51:8]);
            chk("rd_idx", rd_idx, e[7:0]);
          end
          nxt = (resp_q.size() != 0) ? resp_q.pop_front() : 16'h0;
        end
      end
    end
  end

  // invalidation monitor: optional stall, stability while stalled, scoreboard compare on ack
  initial begin
    int          wait_cnt;
    logic        prev_wait;
    logic [11:0] prev, e;
    wait_cnt = 0; prev_wait = 1'b0; prev = '0;
    inv_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n || !inv_vld) begin
        inv_ack = 1'b0; wait_cnt = 0; prev_wait = 1'b0;
      end else begin
        if (prev_wait) chk("inv_stable", {inv_all, inv_idx, inv_way}, prev);
        if (wait_cnt >= inv_delay) begin
          inv_ack = 1'b1; wait_cnt = 0; prev_wait = 1'b0;
          chk("inv_expected", exp_inv_q.size() != 0, 1);
          if (exp_inv_q.size() != 0) begin
            e = exp_inv_q.pop_front();
            chk("inv_all", inv_all, e[11]);
            chk("inv_idx", inv_idx, e[10:3]);
            chk("inv_way", inv_way, e[2:0]);
          end
        end else begin
          inv_ack = 1'b0; wait_cnt++; prev_wait = 1'b1;
          prev = {inv_all, inv_idx, inv_way};
        end
      end
    end
  end

  initial begin
    int cyc;
    req = 1'b0; paddr = '0; all_i = 1'b0;
    apply_reset();

    // reset state
    chk("rst_ack", ack, 0);
    chk("rst_rd_req", rd_req, 0);
    chk("rst_rd_tag", rd_tag, 0);
    chk("rst_rd_idx", rd_idx, 0);
    chk("rst_rd_off", rd_off, 0);
    chk("rst_tag_only", rd_to, 1);
    chk("rst_inv_vld", inv_vld, 0);
    chk("rst_inv_all", inv_all, 0);
    chk("rst_inv_idx", inv_idx, 0);
    chk("rst_inv_way", inv_way, 0);
    chk("rst_busy", busy, 0);

    // single hit, minimum latency
    expect_line(56'h0000_0000_8000_1230, 8'hFF, 8'h04);
    exp_inv(1'b0, 8'h23, 3'd2);
    send(56'h0000_0000_8000_1230, 1'b0, 1'b1, 1'b0, 1'b0, "acc_single");
    cyc = 1;
    while (!inv_vld && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("first_inv_latency", cyc, 4);
    wait_idle("single");

    // tag match on an invalid way: no invalidation, pop right after RESULT
    expect_line(56'h0000_0000_1234_5670, 8'hFB, 8'h04);
    send(56'h0000_0000_1234_5670, 1'b0, 1'b1, 1'b0, 1'b0, "acc_miss");
    cyc = 1;
    while (busy && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("miss_pop_cycle", cyc, 4);
    wait_idle("miss");

    // multi-hit with stalled acks
    inv_delay = 3;
    expect_line(56'h0000_00AB_CDEF_0AC0, 8'h83, 8'hC2);
    exp_inv(1'b0, 8'hAC, 3'd1);
    exp_inv(1'b0, 8'hAC, 3'd7);
    send(56'h0000_00AB_CDEF_0AC0, 1'b0, 1'b1, 1'b0, 1'b0, "acc_multi");
    wait_idle("multi");
    inv_delay = 0;
    apply_reset();

    // backpressure and coalescing
    rd_ack_en = 0;
    expect_line(56'h0000_0000_0001_0010, 8'h00, 8'h00);
    expect_line(56'h0000_0000_0002_0020, 8'h01, 8'h01);
    exp_inv(1'b0, 8'h02, 3'd0);
    expect_line(56'h0000_0000_0003_0030, 8'hFF, 8'h00);
    expect_line(56'h0000_0000_0004_0040, 8'hFF, 8'h20);
    exp_inv(1'b0, 8'h04, 3'd5);
    expect_line(56'h0000_0000_0005_0050, 8'h00, 8'hFF);
    send(56'h0000_0000_0001_0010, 1'b0, 1'b1, 1'b1, 1'b1, "bp_a");
    send(56'h0000_0000_0002_0020, 1'b0, 1'b1, 1'b1, 1'b1, "bp_b");
    send(56'h0000_0000_0003_0030, 1'b0, 1'b1, 1'b1, 1'b1, "bp_c");
    send(56'h0000_0000_0002_002C, 1'b0, 1'b1, 1'b1, 1'b1, "bp_dup");
    send(56'h0000_0000_0004_0040, 1'b0, 1'b1, 1'b1, 1'b0, "bp_d");
    req = 1'b1; paddr = 56'h0000_0000_0005_0050; all_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_full_no_ack", ack, 0);
      @(negedge clk);
    end
    rd_ack_en = 1;
    cyc = 0;
    #1;
    while (!ack && cyc < 50) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    chk("bp_e_accepted", ack, 1);
    @(negedge clk);
    req = 1'b0; paddr = '0;
    wait_idle("backpressure");
    apply_reset();

    // flush-all queued behind line requests; all requests never coalesce
    rd_ack_en = 0;
    expect_line(56'h0000_0000_0006_0060, 8'hFF, 8'h08);
    exp_inv(1'b0, 8'h06, 3'd3);
    expect_line(56'h0000_0000_0007_0070, 8'hFF, 8'h11);
    exp_inv(1'b0, 8'h07, 3'd0);
    exp_inv(1'b0, 8'h07, 3'd4);
    exp_inv(1'b1, 8'h00, 3'd0);
    exp_inv(1'b1, 8'h00, 3'd0);
    send(56'h0000_0000_0006_0060, 1'b0, 1'b1, 1'b0, 1'b0, "fl_l1");
    send(56'h0000_0000_0007_0070, 1'b0, 1'b1, 1'b0, 1'b0, "fl_l2");
    send(56'h0000_0000_0006_0060, 1'b1, 1'b1, 1'b0, 1'b0, "fl_all1");
    send(56'h0000_0000_0006_0060, 1'b1, 1'b1, 1'b0, 1'b0, "fl_all2");
    rd_ack_en = 1;
    wait_idle("flush");

    // asynchronous reset while an invalidation is pending
    inv_delay = 100;
    expect_line(56'h0000_0000_0009_9990, 8'hFF, 8'h0F);
    send(56'h0000_0000_0009_9990, 1'b0, 1'b1, 1'b0, 1'b0, "rst_mid_acc");
    cyc = 0;
    while (!inv_vld && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_mid_in_way_req", inv_vld, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_inv_vld", inv_vld, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_inv_idx", inv_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    inv_delay = 0;
    @(negedge clk);
    expect_line(56'h0000_0000_000A_AAA0, 8'hFF, 8'h01);
    exp_inv(1'b0, 8'hAA, 3'd0);
    send(56'h0000_0000_000A_AAA0, 1'b0, 1'b1, 1'b0, 1'b0, "post_rst_acc");
    wait_idle("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
